// File: rtl/fir_host_if.sv
// Frame controller and nibble serializer/deserializer between a parallel
// sample stream and a nibble-serial FIR processing-element chain.
module fir_host_if #(
  parameter int FRAME_LEN = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        pe_rdy,
  output logic [3:0]  pe_xin,
  output logic [3:0]  pe_yin,
  input  logic [3:0]  pe_yout,
  input  logic        pe_vld,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        sync_err,
  output logic        busy
);

  typedef enum logic {IDLE, FRAME} state_t;

  localparam logic [7:0] F_LAST = 8'(FRAME_LEN - 1);

  state_t      state, state_nx;
  logic [7:0]  f, f_nx;
  logic        accept;
  logic [7:0]  x_reg;
  logic [15:0] acc;

  // The accumulator seed for the first PE is always zero.
  assign pe_yin = 4'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      f     <= 8'd0;
    end else begin
      state <= state_nx;
      f     <= f_nx;
    end
  end

  // in_ready depends only on state/counter, never on in_valid.
  always_comb begin
    in_ready = (state == IDLE) || (f == F_LAST);
    accept   = in_valid && in_ready;
    state_nx = state;
    f_nx     = f;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = FRAME;
          f_nx     = 8'd0;
        end
      end
      FRAME: begin
        if (f == F_LAST) begin
          f_nx = 8'd0;
          if (!accept) state_nx = IDLE;
        end else begin
          f_nx = f + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        f_nx     = 8'd0;
      end
    endcase
  end

  // Outputs are registered one cycle ahead of the frame slot they belong to,
  // so each is set on the edge that ends the preceding frame cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_rdy    <= 1'b0;
      pe_xin    <= 4'h0;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      sync_err  <= 1'b0;
      busy      <= 1'b0;
      acc       <= 16'h0000;
      x_reg     <= 8'h00;
    end else begin
      pe_rdy    <= accept;
      pe_xin    <= 4'h0;
      out_valid <= 1'b0;
      busy      <= (state_nx == FRAME);
      if (accept) x_reg <= in_data;
      if (state == FRAME) begin
        case (f)
          8'd0: pe_xin <= x_reg[3:0];
          8'd1: begin
            pe_xin    <= x_reg[7:4];
            acc[3:0]  <= pe_yout;
          end
          8'd2: acc[7:4]  <= pe_yout;
          8'd3: acc[11:8] <= pe_yout;
          8'd4: begin
            acc[15:12] <= pe_yout;
            out_valid  <= 1'b1;
            out_data   <= {pe_yout, acc[11:0]};
          end
          default: ;
        endcase
        // The chain's valid must appear exactly in f5 and nowhere else.
        if ((f == 8'd5) != pe_vld) sync_err <= 1'b1;
      end
    end
  end

endmodule
